// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and sizing helpers for the AES round controller family
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } aes_state_e;

    // Round counter holds 0..14, phase counter holds 0..7
    localparam int ROUND_W = 4;
    localparam int PHASE_W = 3;

    // Number of full rounds for a given key length
    function automatic int aes_nr(input int key_bits);
        case (key_bits)
            192:     return 12;
            256:     return 14;
            default: return 10;
        endcase
    endfunction

endpackage

// File: rtl/aes_pending_slot.sv
// rtl/aes_pending_slot.sv - one-entry block holding register with same-cycle pop and push
module aes_pending_slot (
    input  logic         clk,
    input  logic         kill_n,
    input  logic         push,
    input  logic [127:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [127:0] data
);

    logic         valid_q;
    logic [127:0] data_q;

    // A push wins over a pop so the slot can free and refill in one cycle
    always_ff @(posedge clk) begin
        if (!kill_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (push) begin
            valid_q <= 1'b1;
            data_q  <= push_data;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/aes_round_ctrl_param.sv
// rtl/aes_round_ctrl_param.sv - parametrised AES round scheduler with optional pending block
module aes_round_ctrl_param
    import aes_pkg::*;
#(
    parameter int KEY_BITS      = 128,
    parameter int CYC_PER_ROUND = 3,
    parameter int QUEUE_EN      = 1
) (
    input  logic         clk,
    input  logic         kill_n,
    input  logic         in_en,
    input  logic [127:0] in_data,
    output logic [127:0] core_data,
    output logic         start,
    output logic         en_mixcol,
    output logic [3:0]   round_idx,
    output logic         key_ready,
    output logic         idle,
    output logic         out_en,
    output logic         in_en_collision_irq_pulse
);

    localparam logic [ROUND_W-1:0] NR_L    = ROUND_W'(aes_nr(KEY_BITS));
    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(CYC_PER_ROUND - 1);
    localparam logic               QEN     = (QUEUE_EN != 0);

    aes_state_e         state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [127:0]       core_q, core_d;
    logic               start_q, start_d;
    logic               mix_q, mix_d;
    logic [3:0]         ridx_q, ridx_d;
    logic               krdy_q, krdy_d;
    logic               idle_q, idle_d;
    logic               oen_q, oen_d;
    logic               irq_q, irq_d;

    logic               busy, consumed, push, pop;
    logic               slot_valid;
    logic [127:0]       slot_data;

    aes_pending_slot u_slot (
        .clk       (clk),
        .kill_n    (kill_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .valid     (slot_valid),
        .data      (slot_data)
    );

    // Next state plus next values of every registered output
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        phase_d  = phase_q;
        core_d   = core_q;
        start_d  = 1'b0;
        oen_d    = 1'b0;
        irq_d    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        consumed = 1'b0;
        busy     = 1'b0;

        case (state_q)
            INIT: begin
                busy    = 1'b1;
                state_d = RUN;
                round_d = ROUND_W'(1);
                phase_d = '0;
            end
            RUN: begin
                busy = 1'b1;
                if (phase_q == PH_LAST) begin
                    if (round_q == NR_L) begin
                        // Next block launches in the DONE cycle; a block arriving
                        // now with an empty slot goes straight to the datapath
                        state_d = DONE;
                        oen_d   = 1'b1;
                        if (slot_valid) begin
                            pop     = 1'b1;
                            start_d = 1'b1;
                            core_d  = slot_data;
                        end else if (QEN && in_en) begin
                            consumed = 1'b1;
                            start_d  = 1'b1;
                            core_d   = in_data;
                        end
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                        phase_d = '0;
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            DONE: begin
                if (start_q) begin
                    busy    = 1'b1;
                    state_d = RUN;
                    round_d = ROUND_W'(1);
                    phase_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!busy && in_en) begin
            state_d = INIT;
            core_d  = in_data;
            start_d = 1'b1;
            round_d = '0;
            phase_d = '0;
        end

        if (busy && in_en && !consumed) begin
            if (QEN && !slot_valid) push = 1'b1;
            else                    irq_d = 1'b1;
        end

        krdy_d = start_d || (state_d == RUN && phase_d == PH_LAST && round_d < NR_L);
        mix_d  = (state_d == RUN) && (round_d < NR_L);
        case (state_d)
            RUN:     ridx_d = round_d;
            DONE:    ridx_d = NR_L;
            default: ridx_d = '0;
        endcase
        idle_d = (state_d == IDLE) && !(push || (slot_valid && !pop));
    end

    // FSM, counters and output registers; kill_n aborts any block in flight
    always_ff @(posedge clk) begin
        if (!kill_n) begin
            state_q <= IDLE;
            round_q <= '0;
            phase_q <= '0;
            core_q  <= '0;
            start_q <= 1'b0;
            mix_q   <= 1'b0;
            ridx_q  <= '0;
            krdy_q  <= 1'b0;
            idle_q  <= 1'b1;
            oen_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            phase_q <= phase_d;
            core_q  <= core_d;
            start_q <= start_d;
            mix_q   <= mix_d;
            ridx_q  <= ridx_d;
            krdy_q  <= krdy_d;
            idle_q  <= idle_d;
            oen_q   <= oen_d;
            irq_q   <= irq_d;
        end
    end

    assign core_data                 = core_q;
    assign start                     = start_q;
    assign en_mixcol                 = mix_q;
    assign round_idx                 = ridx_q;
    assign key_ready                 = krdy_q;
    assign idle                      = idle_q;
    assign out_en                    = oen_q;
    assign in_en_collision_irq_pulse = irq_q;

endmodule

// File: tb/tb_aes_round_ctrl_param.sv
// tb/tb_aes_round_ctrl_param.sv - randomized bench for three controller configurations
module tb_aes_round_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         kill_n;
    logic         in_en;
    logic [127:0] in_data;

    logic [127:0] core_data [3];
    logic         start [3], en_mixcol [3], key_ready [3], idle [3], out_en [3], irq [3];
    logic [3:0]   round_idx [3];

    aes_round_ctrl_param #(.KEY_BITS(128), .CYC_PER_ROUND(3), .QUEUE_EN(1)) u_d0 (
        .clk(clk), .kill_n(kill_n), .in_en(in_en), .in_data(in_data),
        .core_data(core_data[0]), .start(start[0]), .en_mixcol(en_mixcol[0]),
        .round_idx(round_idx[0]), .key_ready(key_ready[0]), .idle(idle[0]),
        .out_en(out_en[0]), .in_en_collision_irq_pulse(irq[0]));

    aes_round_ctrl_param #(.KEY_BITS(256), .CYC_PER_ROUND(2), .QUEUE_EN(1)) u_d1 (
        .clk(clk), .kill_n(kill_n), .in_en(in_en), .in_data(in_data),
        .core_data(core_data[1]), .start(start[1]), .en_mixcol(en_mixcol[1]),
        .round_idx(round_idx[1]), .key_ready(key_ready[1]), .idle(idle[1]),
        .out_en(out_en[1]), .in_en_collision_irq_pulse(irq[1]));

    aes_round_ctrl_param #(.KEY_BITS(128), .CYC_PER_ROUND(3), .QUEUE_EN(0)) u_d2 (
        .clk(clk), .kill_n(kill_n), .in_en(in_en), .in_data(in_data),
        .core_data(core_data[2]), .start(start[2]), .en_mixcol(en_mixcol[2]),
        .round_idx(round_idx[2]), .key_ready(key_ready[2]), .idle(idle[2]),
        .out_en(out_en[2]), .in_en_collision_irq_pulse(irq[2]));

    int total = 0;
    int bad   = 0;

    // Reference schedule: each block is a start cycle s with its out_en at e = s+1+NR*CYC
    int           m_nr  [3] = '{10, 14, 10};
    int           m_cy  [3] = '{3, 2, 3};
    bit           m_qe  [3] = '{1'b1, 1'b1, 1'b0};
    bit           have  [3] = '{3{1'b0}};
    int           s     [3] = '{3{-1000}};
    int           e     [3] = '{3{-1000}};
    int           pe    [3] = '{3{-1000}};
    bit           pend_v[3] = '{3{1'b0}};
    logic [127:0] pend_d[3];
    logic [127:0] m_core[3] = '{3{128'h0}};
    bit           irq_x [3] = '{3{1'b0}};
    int           cyc = 0;
    int           oe_cnt [3], kr_cnt [3], last_oe [3];

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int i, input bit ie, input logic [127:0] d, input bit k);
        bit took;
        took     = 1'b0;
        irq_x[i] = 1'b0;
        if (!k) begin
            have[i] = 0; pend_v[i] = 0; m_core[i] = '0;
            s[i] = -1000; e[i] = -1000; pe[i] = -1000;
        end else if (!(have[i] && cyc < e[i])) begin
            if (ie) begin
                have[i] = 1; s[i] = cyc + 1; e[i] = s[i] + 1 + m_nr[i] * m_cy[i]; m_core[i] = d;
            end
        end else begin
            if (cyc + 1 == e[i] && (pend_v[i] || (m_qe[i] && ie))) begin
                pe[i] = e[i]; s[i] = e[i]; e[i] = s[i] + 1 + m_nr[i] * m_cy[i];
                if (pend_v[i]) begin
                    m_core[i] = pend_d[i]; pend_v[i] = 0;
                    if (ie) irq_x[i] = 1;
                end else begin
                    m_core[i] = d;
                end
                took = 1'b1;
            end
            if (ie && !took) begin
                if (m_qe[i] && !pend_v[i]) begin pend_v[i] = 1; pend_d[i] = d; end
                else irq_x[i] = 1;
            end
        end
    endtask

    function automatic logic [9:0] expect_out(input int i, input int n);
        logic st, mix, ki, idl, oe;
        logic [3:0] ri;
        int kk, r, p;
        st = 0; mix = 0; ki = 0; oe = 0; ri = 4'd0;
        if (have[i] && (n == e[i] || n == pe[i])) begin
            oe = 1; ri = 4'(m_nr[i]); st = (n == s[i]); ki = st;
        end else if (have[i] && n == s[i]) begin
            st = 1; ki = 1;
        end else if (have[i] && n > s[i] && n < e[i]) begin
            kk = n - s[i] - 1; r = kk / m_cy[i] + 1; p = kk % m_cy[i];
            ri = 4'(r); mix = (r < m_nr[i]); ki = (p == m_cy[i] - 1) && (r < m_nr[i]);
        end
        idl = !(have[i] && n <= e[i]) && !pend_v[i];
        return {st, mix, ri, ki, idl, oe, irq_x[i]};
    endfunction

    task automatic step(input bit ie, input logic [127:0] d, input bit k);
        in_en = ie; in_data = d; kill_n = k;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i, ie, d, k);
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("ctl%0d@%0d", i, cyc),
                      {start[i], en_mixcol[i], round_idx[i], key_ready[i], idle[i], out_en[i], irq[i]},
                      expect_out(i, cyc));
            check_val($sformatf("core%0d@%0d", i, cyc), core_data[i], m_core[i]);
            if (out_en[i]) begin oe_cnt[i]++; last_oe[i] = cyc; end
            if (key_ready[i]) kr_cnt[i]++;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step(1'b0, rnd128(), 1'b1);
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 3; i++) begin oe_cnt[i] = 0; kr_cnt[i] = 0; last_oe[i] = -1; end
    endtask

    initial begin
        int t;
        repeat (3) step(1'b0, rnd128(), 1'b0);
        run(5);

        // single block, check latency and key_ready count
        clr_cnt(); t = cyc;
        step(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1);
        run(60);
        check_val("lat_d0", 128'(last_oe[0] - t), 128'd32);
        check_val("lat_d1", 128'(last_oe[1] - t), 128'd30);
        check_val("krdy_d0", 128'(kr_cnt[0]), 128'd10);
        check_val("oe_d0", 128'(oe_cnt[0]), 128'd1);

        // A at t, B at t+5, C at t+6
        clr_cnt();
        step(1'b1, rnd128(), 1'b1); run(4);
        step(1'b1, rnd128(), 1'b1); step(1'b1, rnd128(), 1'b1);
        run(100);
        check_val("oe3_d0", 128'(oe_cnt[0]), 128'd2);
        check_val("oe3_d1", 128'(oe_cnt[1]), 128'd2);
        check_val("oe3_d2", 128'(oe_cnt[2]), 128'd1);

        // kill mid-round with a block pending
        step(1'b1, rnd128(), 1'b1); run(4);
        step(1'b1, rnd128(), 1'b1); run(9);
        clr_cnt();
        step(1'b0, rnd128(), 1'b0);
        run(100);
        check_val("killoe_d0", 128'(oe_cnt[0]), 128'd0);
        check_val("killoe_d1", 128'(oe_cnt[1]), 128'd0);
        step(1'b1, rnd128(), 1'b1); run(60);
        check_val("fresh_d0", 128'(oe_cnt[0]), 128'd1);

        // second block in the last RUN cycle, then in an idle DONE cycle
        step(1'b1, rnd128(), 1'b1); run(30); step(1'b1, rnd128(), 1'b1); run(80);
        step(1'b1, rnd128(), 1'b1); run(31); step(1'b1, rnd128(), 1'b1); run(80);

        // random traffic with occasional kills
        for (int j = 0; j < 3000; j++)
            step($urandom_range(0, 15) == 0, rnd128(), $urandom_range(0, 399) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
